matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, meaning the width of memory words and bank rows.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the external read-address width.
REQ-003 The block SHALL have parameter NUM_BANKS, default 4, meaning the number of destination SRAM banks, a power of two.
REQ-004 The block SHALL have parameter BANK_DEPTH, default 128, meaning the rows per bank, a power of two.
REQ-005 The block SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding read requests.
REQ-006 The block SHALL define CNT_W = clog2(NUM_BANKS*BANK_DEPTH)+1 and BA_W = clog2(BANK_DEPTH) as derived localparams.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset: vsi_clk  in  1  clock, all logic on its rising edge.
REQ-008 The block SHALL have port vsi_rst  in  1  asynchronous, active-high reset.
REQ-009 The block SHALL have port vsi_start  in  1  single-cycle transfer request.
REQ-010 The block SHALL have port vsi_mode  in  1  mapping mode: 0 = interleaved, 1 = blocked.
REQ-011 The block SHALL have port vsi_base  in  ADDR_W  first row byte address.
REQ-012 The block SHALL have port vsi_stride  in  ADDR_W  byte distance between consecutive rows.
REQ-013 The block SHALL have port vsi_rows  in  CNT_W  number of rows to load.
REQ-014 The block SHALL have port vsi_busy  out  1  transfer in progress.
REQ-015 The block SHALL have port vsi_done  out  1  one-cycle completion pulse.
REQ-016 The block SHALL have port vsi_err  out  1  sticky error flag.
REQ-017 The block SHALL have ports vsi_raddr  out  ADDR_W, vsi_raddr_valid  out  1, and vsi_raddr_ready  in  1, forming the read-request channel.
REQ-018 The block SHALL have ports vsi_rdata  in  DATA_W and vsi_rdata_valid  in  1, forming the in-order read-return channel with no backpressure.
REQ-019 The block SHALL have ports vsi_bank_wen  out  NUM_BANKS (one-hot), vsi_bank_waddr  out  BA_W, and vsi_bank_wdata  out  DATA_W, forming the bank write port.

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, DRAIN and DONE; vsi_busy SHALL be 1 in ISSUE and DRAIN only.
REQ-021 In IDLE, vsi_start SHALL latch mode, base, stride and rows and clear vsi_err.
- Then, if rows == 0, the block SHALL go to DONE.
- Else, if rows > NUM_BANKS*BANK_DEPTH, the block SHALL set vsi_err and go to DONE.
- Otherwise it SHALL go to ISSUE.
REQ-022 vsi_start SHALL be ignored outside IDLE.
REQ-023 In ISSUE, vsi_raddr_valid SHALL be 1 while issued < rows and outstanding < MAX_OUT.
- vsi_raddr SHALL equal base + issued*stride, modulo 2^ADDR_W (wrap-around permitted).
REQ-024 vsi_raddr and vsi_raddr_valid SHALL remain stable while valid=1 and ready=0.
REQ-025 A request SHALL be issued on valid & ready; when issued reaches rows, the block SHALL go to DRAIN.
REQ-026 The outstanding counter SHALL increment on an issue and decrement on vsi_rdata_valid; when both occur in the same cycle it SHALL be unchanged.
REQ-027 The k-th return (k = 0..rows-1) SHALL be written exactly one cycle after its vsi_rdata_valid, with vsi_bank_wdata equal to the captured vsi_rdata.
- Mode 0: bank = k mod NUM_BANKS, addr = k / NUM_BANKS.
- Mode 1: bank = k / BANK_DEPTH, addr = k mod BANK_DEPTH.
REQ-028 vsi_bank_wen SHALL be all-zero in every cycle with no write.
REQ-029 In ISSUE or DRAIN, vsi_rdata_valid with outstanding == 0 SHALL set vsi_err and SHALL produce no write.
REQ-030 In IDLE or DONE, vsi_rdata_valid SHALL be ignored, with no error and no write.
REQ-031 DRAIN SHALL go to DONE in the cycle after the final bank write.
REQ-032 DONE SHALL assert vsi_done for exactly one cycle and SHALL return to IDLE.
REQ-033 vsi_err SHALL hold until the next accepted vsi_start or reset.

Reset
REQ-034 While vsi_rst = 1, the block SHALL immediately force state IDLE and clear all counters.
- Outputs: vsi_busy=0, vsi_done=0, vsi_err=0, vsi_raddr_valid=0, vsi_raddr=0, vsi_bank_wen=0, vsi_bank_waddr=0, vsi_bank_wdata=0.
REQ-035 Reset during a transfer SHALL abort it; returns arriving after reset SHALL be ignored per REQ-030.

Verification
REQ-036 Scenario "interleave": mode=0, base=0x1000, stride=0x10, rows=8, ready=1, 2-cycle return latency.
- Required: raddr sequence 0x1000..0x1070.
- Rows 0..7 written to bank0..3 at addresses 0,0,0,0,1,1,1,1.
- One vsi_done pulse.
REQ-037 Scenario "blocked": mode=1, rows=130.
- Required: rows 0..127 written to bank0 at addr 0..127.
- Rows 128..129 written to bank1 at addr 0..1.
REQ-038 Scenario "backpressure": ready held low for 5 cycles with return latency of 20 cycles.
- Required: raddr is stable while stalled.
- vsi_raddr_valid never asserts with 4 requests outstanding.
- No request is lost or duplicated.
REQ-039 Scenario "boundaries".
- rows=0: vsi_done on the next cycle, with no request and err=0.
- rows=513: err=1 and vsi_done, with no request.
- base=0xFFFFFFF0, stride=0x10, rows=2: raddr sequence 0xFFFFFFF0, 0x00000000.
REQ-040 Scenario "reset mid-transfer": assert vsi_rst after 3 of 8 rows.
- Required: all outputs go to zero immediately.
- Late returns produce no write and err=0.
- A new vsi_start completes normally.
REQ-041 Scenario "spurious": vsi_rdata_valid with outstanding = 0 while busy.
- Required: err=1 and no write.
- vsi_start during busy is ignored.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: streams a strided matrix from external memory into a set of
// SRAM banks. Rows are requested in order on a valid/ready channel, returned
// in order with no backpressure, and written to a bank chosen by the
// interleaved (row mod banks) or blocked (row div depth) mapping.
//
// Request handshake: vsi_raddr_valid rises only when a request may be issued;
// once high, vsi_raddr_valid and vsi_raddr hold until the cycle in which
// vsi_raddr_ready is also high, and that cycle transfers exactly one request.
module matrix_loader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 128,
  parameter int MAX_OUT    = 4,
  localparam int CNT_W     = $clog2(NUM_BANKS * BANK_DEPTH) + 1,
  localparam int BA_W      = $clog2(BANK_DEPTH)
) (
  input  logic                 vsi_clk,
  input  logic                 vsi_rst,
  input  logic                 vsi_start,
  input  logic                 vsi_mode,
  input  logic [ADDR_W-1:0]    vsi_base,
  input  logic [ADDR_W-1:0]    vsi_stride,
  input  logic [CNT_W-1:0]     vsi_rows,
  output logic                 vsi_busy,
  output logic                 vsi_done,
  output logic                 vsi_err,
  output logic [ADDR_W-1:0]    vsi_raddr,
  output logic                 vsi_raddr_valid,
  input  logic                 vsi_raddr_ready,
  input  logic [DATA_W-1:0]    vsi_rdata,
  input  logic                 vsi_rdata_valid,
  output logic [NUM_BANKS-1:0] vsi_bank_wen,
  output logic [BA_W-1:0]      vsi_bank_waddr,
  output logic [DATA_W-1:0]    vsi_bank_wdata,
  output logic [1:0]           dbg_state
);

  localparam int NB_SH = $clog2(NUM_BANKS);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] TOTAL_ROWS = CNT_W'(NUM_BANKS * BANK_DEPTH);
  localparam logic [OUT_W-1:0] OUT_LIMIT  = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_W-1:0]     stride_q, stride_d;
  logic [CNT_W-1:0]      rows_q, rows_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      ret_q, ret_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  err_q, err_d;
  logic [NUM_BANKS-1:0]  wen_q, wen_d;
  logic [BA_W-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  busy;
  logic                  req_valid;
  logic                  issue;
  logic                  accept;
  logic                  spurious;
  logic [CNT_W-1:0]      bank_idx;
  logic [CNT_W-1:0]      row_addr;
  logic [NUM_BANKS-1:0]  wen_map;

  assign busy            = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign req_valid       = (state_q == S_ISSUE) && (issued_q < rows_q) && (out_q < OUT_LIMIT);
  assign issue           = req_valid && vsi_raddr_ready;
  // A return only counts against a request that is actually outstanding.
  assign accept          = vsi_rdata_valid && busy && (out_q != '0);
  assign spurious        = vsi_rdata_valid && busy && (out_q == '0);

  assign vsi_busy        = busy;
  assign vsi_done        = (state_q == S_DONE);
  assign vsi_err         = err_q;
  assign vsi_raddr       = addr_q;
  assign vsi_raddr_valid = req_valid;
  assign vsi_bank_wen    = wen_q;
  assign vsi_bank_waddr  = waddr_q;
  assign vsi_bank_wdata  = wdata_q;
  assign dbg_state       = state_q;

  // Map the index of the next return to a bank and a row inside that bank.
  always_comb begin
    bank_idx = '0;
    row_addr = '0;
    if (mode_q) begin
      bank_idx = ret_q >> BA_W;
      row_addr = ret_q & CNT_W'(BANK_DEPTH - 1);
    end else begin
      bank_idx = ret_q & CNT_W'(NUM_BANKS - 1);
      row_addr = ret_q >> NB_SH;
    end
    wen_map = NUM_BANKS'(1) << bank_idx;
  end

  // Next-state, counter and write-stage logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    stride_d = stride_q;
    rows_d   = rows_q;
    issued_d = issued_q;
    ret_d    = ret_q;
    out_d    = out_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wen_d    = '0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    // The address accumulates the stride so no multiplier is needed;
    // it wraps naturally at 2^ADDR_W.
    if (issue) begin
      issued_d = issued_q + 1'b1;
      addr_d   = addr_q + stride_q;
    end

    case ({issue, accept})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (accept) begin
      ret_d   = ret_q + 1'b1;
      wen_d   = wen_map;
      waddr_d = BA_W'(row_addr);
      wdata_d = vsi_rdata;
    end

    if (spurious) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (vsi_start) begin
          mode_d   = vsi_mode;
          stride_d = vsi_stride;
          rows_d   = vsi_rows;
          addr_d   = vsi_base;
          issued_d = '0;
          ret_d    = '0;
          out_d    = '0;
          err_d    = 1'b0;
          if (vsi_rows == '0) begin
            state_d = S_DONE;
          end else if (vsi_rows > TOTAL_ROWS) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue && (issued_d == rows_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final write is on the bank port this cycle; finish next cycle.
        if ((wen_q != '0) && (ret_q == rows_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge vsi_clk or posedge vsi_rst) begin
    if (vsi_rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      stride_q <= '0;
      rows_q   <= '0;
      issued_q <= '0;
      ret_q    <= '0;
      out_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      wen_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      stride_q <= stride_d;
      rows_q   <= rows_d;
      issued_q <= issued_d;
      ret_q    <= ret_d;
      out_q    <= out_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Testbench for matrix_loader: directed transfers against an in-order memory
// model with programmable return latency, with request and bank-write
// scoreboards.
module tb_matrix_loader;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 32;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 128;
  localparam int MAX_OUT    = 4;
  localparam int CNT_W      = 10;
  localparam int BA_W       = 7;
  localparam int W          = NUM_BANKS + BA_W + DATA_W;

  logic                 clk;
  logic                 vsi_rst;
  logic                 vsi_start;
  logic                 vsi_mode;
  logic [ADDR_W-1:0]    vsi_base;
  logic [ADDR_W-1:0]    vsi_stride;
  logic [CNT_W-1:0]     vsi_rows;
  logic                 vsi_busy;
  logic                 vsi_done;
  logic                 vsi_err;
  logic [ADDR_W-1:0]    vsi_raddr;
  logic                 vsi_raddr_valid;
  logic                 vsi_raddr_ready;
  logic [DATA_W-1:0]    vsi_rdata;
  logic                 vsi_rdata_valid;
  logic [NUM_BANKS-1:0] vsi_bank_wen;
  logic [BA_W-1:0]      vsi_bank_waddr;
  logic [DATA_W-1:0]    vsi_bank_wdata;
  logic [1:0]           dbg_state;

  matrix_loader dut (
    .vsi_clk         (clk),
    .vsi_rst         (vsi_rst),
    .vsi_start       (vsi_start),
    .vsi_mode        (vsi_mode),
    .vsi_base        (vsi_base),
    .vsi_stride      (vsi_stride),
    .vsi_rows        (vsi_rows),
    .vsi_busy        (vsi_busy),
    .vsi_done        (vsi_done),
    .vsi_err         (vsi_err),
    .vsi_raddr       (vsi_raddr),
    .vsi_raddr_valid (vsi_raddr_valid),
    .vsi_raddr_ready (vsi_raddr_ready),
    .vsi_rdata       (vsi_rdata),
    .vsi_rdata_valid (vsi_rdata_valid),
    .vsi_bank_wen    (vsi_bank_wen),
    .vsi_bank_waddr  (vsi_bank_waddr),
    .vsi_bank_wdata  (vsi_bank_wdata),
    .dbg_state       (dbg_state)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } mem_req_t;

  mem_req_t          mem_q[$];
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 2;
  int done_cnt = 0;
  int wr_cnt = 0;
  int req_cnt = 0;
  int stall_viol = 0;
  int stall_seen = 0;
  int out_viol = 0;
  int lat_viol = 0;
  bit prev_stall = 0;
  bit prev_rv = 0;
  bit spur = 0;
  logic [ADDR_W-1:0] prev_addr = '0;

  logic [ADDR_W-1:0] il_raddr[8] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030,
                                     32'h1040, 32'h1050, 32'h1060, 32'h1070};
  int il_bank[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int il_addr[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
  endfunction

  function automatic logic [W-1:0] exp_wr(input int bank, input int addr, input logic [ADDR_W-1:0] a);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    oh[bank] = 1'b1;
    return {oh, BA_W'(addr), mem_data(a)};
  endfunction

  task automatic push_exp(input logic m, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                          input int rows);
    logic [ADDR_W-1:0] a;
    int bank;
    int ad;
    for (int k = 0; k < rows; k++) begin
      a    = b + s * 32'(k);
      bank = m ? (k / BANK_DEPTH) : (k % NUM_BANKS);
      ad   = m ? (k % BANK_DEPTH) : (k / NUM_BANKS);
      exp_addr_q.push_back(a);
      exp_q.push_back(exp_wr(bank, ad, a));
    end
  endtask

  // Driver: one-cycle start pulse with the transfer parameters
  task automatic do_start(input logic m, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                          input logic [CNT_W-1:0] r);
    @(posedge clk);
    #1;
    vsi_mode   = m;
    vsi_base   = b;
    vsi_stride = s;
    vsi_rows   = r;
    vsi_start  = 1'b1;
    @(posedge clk);
    #1;
    vsi_start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!vsi_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 256'(vsi_done), 256'(1));
  endtask

  // Memory model: in-order returns after `lat` cycles, plus an injected
  // spurious return on request.
  initial forever begin
    @(posedge clk);
    #1;
    if (spur) begin
      vsi_rdata_valid = 1'b1;
      vsi_rdata       = {4{32'hDEAD_BEEF}};
      spur            = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      vsi_rdata_valid = 1'b1;
      vsi_rdata       = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      vsi_rdata_valid = 1'b0;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge
  initial forever begin
    mem_req_t r;
    @(negedge clk);
    if (vsi_raddr_valid && (mem_q.size() + int'(vsi_rdata_valid)) >= MAX_OUT) out_viol++;
    if (vsi_raddr_valid && vsi_raddr_ready) begin
      req_cnt++;
      if (exp_addr_q.size() == 0) check("raddr_extra", 256'(exp_addr_q.size()), 256'(1));
      else check("raddr", 256'(vsi_raddr), 256'(exp_addr_q.pop_front()));
      r.addr = vsi_raddr;
      r.due  = cyc + lat;
      mem_q.push_back(r);
    end
    if (vsi_bank_wen != '0) begin
      wr_cnt++;
      if (!prev_rv) lat_viol++;
      if (exp_q.size() == 0) check("wr_extra", 256'(exp_q.size()), 256'(1));
      else check("wr", 256'({vsi_bank_wen, vsi_bank_waddr, vsi_bank_wdata}), 256'(exp_q.pop_front()));
    end
    prev_rv = vsi_rdata_valid;
    if (prev_stall && !(vsi_raddr_valid && vsi_raddr == prev_addr)) stall_viol++;
    prev_stall = vsi_raddr_valid && !vsi_raddr_ready && !vsi_rst;
    if (prev_stall) stall_seen++;
    prev_addr = vsi_raddr;
    if (vsi_done) done_cnt++;
  end

  // Directed scenarios
  initial begin
    int d0;
    int w0;
    int r0;
    int n;
    vsi_rst = 1'b0;
    vsi_start = 1'b0;
    vsi_mode = 1'b0;
    vsi_base = '0;
    vsi_stride = '0;
    vsi_rows = '0;
    vsi_raddr_ready = 1'b0;
    vsi_rdata = '0;
    vsi_rdata_valid = 1'b0;

    // Reset state
    #3 vsi_rst = 1'b1;
    #1;
    check("rst_outs", 256'({vsi_busy, vsi_done, vsi_err, vsi_raddr_valid, vsi_raddr,
                            vsi_bank_wen, vsi_bank_waddr, vsi_bank_wdata}), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));
    repeat (3) @(posedge clk);
    #1 vsi_rst = 1'b0;

    // Interleave: directed address and bank table
    lat = 2;
    vsi_raddr_ready = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(il_raddr[k]);
      exp_q.push_back(exp_wr(il_bank[k], il_addr[k], il_raddr[k]));
    end
    do_start(1'b0, 32'h1000, 32'h10, 10'd8);
    @(negedge clk);
    check("il_busy", 256'(vsi_busy), 256'(1));
    wait_done(200);
    repeat (3) @(negedge clk);
    check("il_done_cnt", 256'(done_cnt - d0), 256'(1));
    check("il_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));
    check("il_err", 256'(vsi_err), 256'(0));

    // Blocked: 130 rows spill from bank0 into bank1
    lat = 3;
    w0 = wr_cnt;
    push_exp(1'b1, 32'h2000, 32'h40, 130);
    do_start(1'b1, 32'h2000, 32'h40, 10'd130);
    wait_done(2000);
    repeat (3) @(negedge clk);
    check("bl_wr_cnt", 256'(wr_cnt - w0), 256'(130));
    check("bl_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));

    // Backpressure: ready low for 5 cycles, long return latency
    lat = 20;
    vsi_raddr_ready = 1'b0;
    stall_viol = 0;
    stall_seen = 0;
    out_viol = 0;
    r0 = req_cnt;
    push_exp(1'b0, 32'h5000, 32'h20, 8);
    do_start(1'b0, 32'h5000, 32'h20, 10'd8);
    repeat (5) @(posedge clk);
    #1 vsi_raddr_ready = 1'b1;
    wait_done(500);
    repeat (3) @(negedge clk);
    check("bp_stable", 256'(stall_viol), 256'(0));
    check("bp_stall_seen", 256'(stall_seen >= 4), 256'(1));
    check("bp_max_out", 256'(out_viol), 256'(0));
    check("bp_req_cnt", 256'(req_cnt - r0), 256'(8));
    check("bp_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));

    // Boundaries: zero rows
    lat = 2;
    r0 = req_cnt;
    do_start(1'b0, 32'h100, 32'h10, 10'd0);
    @(negedge clk);
    check("b0_done", 256'(vsi_done), 256'(1));
    check("b0_err", 256'(vsi_err), 256'(0));
    repeat (2) @(negedge clk);
    check("b0_req", 256'(req_cnt - r0), 256'(0));

    // Boundaries: too many rows
    do_start(1'b0, 32'h100, 32'h10, 10'd513);
    @(negedge clk);
    check("b513_done", 256'(vsi_done), 256'(1));
    check("b513_err", 256'(vsi_err), 256'(1));
    repeat (2) @(negedge clk);
    check("b513_req", 256'(req_cnt - r0), 256'(0));
    check("b513_err_hold", 256'(vsi_err), 256'(1));

    // Boundaries: address wrap 0xFFFFFFF0 -> 0x00000000
    exp_addr_q.push_back(32'hFFFF_FFF0);
    exp_addr_q.push_back(32'h0000_0000);
    exp_q.push_back(exp_wr(0, 0, 32'hFFFF_FFF0));
    exp_q.push_back(exp_wr(1, 0, 32'h0000_0000));
    do_start(1'b0, 32'hFFFF_FFF0, 32'h10, 10'd2);
    @(negedge clk);
    check("wrap_err_clr", 256'(vsi_err), 256'(0));
    wait_done(200);
    repeat (3) @(negedge clk);
    check("wrap_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));

    // Reset in the middle of a transfer
    lat = 6;
    w0 = wr_cnt;
    push_exp(1'b0, 32'h7000, 32'h10, 8);
    do_start(1'b0, 32'h7000, 32'h10, 10'd8);
    n = 0;
    while ((wr_cnt - w0) < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rm_three_writes", 256'((wr_cnt - w0) >= 3), 256'(1));
    #2 vsi_rst = 1'b1;
    #1;
    check("rm_outs", 256'({vsi_busy, vsi_done, vsi_err, vsi_raddr_valid, vsi_raddr,
                           vsi_bank_wen, vsi_bank_waddr, vsi_bank_wdata}), 256'(0));
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 vsi_rst = 1'b0;
    w0 = wr_cnt;
    repeat (30) @(negedge clk);
    check("rm_late_wr", 256'(wr_cnt - w0), 256'(0));
    check("rm_err", 256'(vsi_err), 256'(0));
    check("rm_mem_drained", 256'(mem_q.size()), 256'(0));
    lat = 2;
    push_exp(1'b0, 32'h8000, 32'h10, 8);
    do_start(1'b0, 32'h8000, 32'h10, 10'd8);
    wait_done(300);
    repeat (3) @(negedge clk);
    check("rm_restart_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));
    check("rm_restart_err", 256'(vsi_err), 256'(0));

    // Spurious return while busy, and a start that must be ignored
    lat = 2;
    vsi_raddr_ready = 1'b0;
    push_exp(1'b0, 32'h9000, 32'h4, 4);
    do_start(1'b0, 32'h9000, 32'h4, 10'd4);
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("sp_err", 256'(vsi_err), 256'(1));
    check("sp_no_wr", 256'(vsi_bank_wen), 256'(0));
    do_start(1'b1, 32'h0, 32'h0, 10'd0);
    @(negedge clk);
    check("sp_busy", 256'(vsi_busy), 256'(1));
    check("sp_state", 256'(dbg_state), 256'(1));
    @(posedge clk);
    #1 vsi_raddr_ready = 1'b1;
    wait_done(300);
    repeat (3) @(negedge clk);
    check("sp_left", 256'(exp_q.size() + exp_addr_q.size()), 256'(0));
    check("sp_err_hold", 256'(vsi_err), 256'(1));

    check("wr_latency", 256'(lat_viol), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
